// File: rtl/alu_seq_if.sv
// Bundle between the multicycle control FSM (master) and the sequential ALU
// (slave). The control side drives start/op/a/b; the ALU returns the
// busy/done handshake plus the registered result and its flags.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             negative;
    logic             overflow;
    logic             illegal;

    modport master (
        output start, op, a, b,
        input  busy, done, result, zero, negative, overflow, illegal
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, zero, negative, overflow, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Registered, parametrised ALU with a start/busy/done handshake.
// Optional iterative shift-add multiply (op 12) is compiled only when the
// macro ALU_SEQ_MUL_EN is defined; otherwise op 12 completes as illegal and
// busy is tied low.
//
// Handshake: start (with op/a/b) is sampled on a rising edge only while
// busy=0. Single-cycle ops raise done for exactly one cycle on the next
// edge, and a new start may be presented in that same done cycle. MUL
// raises busy until its result is ready; starts seen while busy=1 are
// dropped. result and flags are valid from the done cycle and held until
// the next done. Reset always wins over start and aborts a MUL silently.
module alu_seq #(
    parameter int WIDTH = 32,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       reset,
    alu_seq_if.slave   bus,
    output logic [0:0] fsm_state
);
    localparam logic [3:0] OP_SUM  = 4'd0;
    localparam logic [3:0] OP_SHL  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_LOAD = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_SLT  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;

    localparam logic [0:0] S_IDLE = 1'b0;

    logic [0:0]       state;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_overflow;
    logic             nxt_illegal;
    logic [SHW-1:0]   shamt;

    assign shamt     = bus.b[SHW-1:0];
    assign fsm_state = state;

    // Single-cycle datapath: result and flags for the op currently presented.
    always_comb begin
        nxt_result   = '0;
        nxt_overflow = 1'b0;
        nxt_illegal  = 1'b0;
        case (bus.op)
            OP_SUM: begin
                nxt_result   = bus.a + bus.b;
                nxt_overflow = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                               (nxt_result[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                nxt_result   = bus.a - bus.b;
                nxt_overflow = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                               (nxt_result[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SHL:  nxt_result = bus.a << shamt;
            OP_LOAD: nxt_result = bus.b;
            OP_XOR:  nxt_result = bus.a ^ bus.b;
            OP_SHR:  nxt_result = bus.a >> shamt;
            OP_NOT:  nxt_result = ~bus.a;
            OP_AND:  nxt_result = bus.a & bus.b;
            OP_OR:   nxt_result = bus.a | bus.b;
            OP_SRA:  nxt_result = $unsigned($signed(bus.a) >>> shamt);
            OP_SLT:  nxt_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: nxt_result = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            default: nxt_illegal = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd12;
    localparam logic [0:0] S_MUL  = 1'b1;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [SHW-1:0]   cnt;

    // Accumulator value after the current shift-add iteration.
    always_comb begin
        acc_nxt = acc + (b_sh[0] ? a_sh : '0);
    end

    // Control FSM, multiplier iteration and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
            bus.overflow <= 1'b0;
            bus.illegal  <= 1'b0;
            a_sh         <= '0;
            b_sh         <= '0;
            acc          <= '0;
            cnt          <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            a_sh     <= bus.a;
                            b_sh     <= bus.b;
                            acc      <= '0;
                            cnt      <= '0;
                            bus.busy <= 1'b1;
                            state    <= S_MUL;
                        end else begin
                            bus.result   <= nxt_result;
                            bus.zero     <= (nxt_result == '0);
                            bus.negative <= nxt_result[WIDTH-1];
                            bus.overflow <= nxt_overflow;
                            bus.illegal  <= nxt_illegal;
                            bus.done     <= 1'b1;
                        end
                    end
                end
                default: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == SHW'(WIDTH-1)) begin
                        state        <= S_IDLE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.result   <= acc_nxt;
                        bus.zero     <= (acc_nxt == '0);
                        bus.negative <= acc_nxt[WIDTH-1];
                        bus.overflow <= 1'b0;
                        bus.illegal  <= 1'b0;
                    end
                end
            endcase
        end
    end
`else
    assign state    = S_IDLE;
    assign bus.busy = 1'b0;

    // Every accepted op completes on the next edge; op 12 lands in illegal.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.done     <= 1'b0;
            bus.result   <= '0;
            bus.zero     <= 1'b0;
            bus.negative <= 1'b0;
            bus.overflow <= 1'b0;
            bus.illegal  <= 1'b0;
        end else begin
            bus.done <= bus.start;
            if (bus.start) begin
                bus.result   <= nxt_result;
                bus.zero     <= (nxt_result == '0);
                bus.negative <= nxt_result[WIDTH-1];
                bus.overflow <= nxt_overflow;
                bus.illegal  <= nxt_illegal;
            end
        end
    end
`endif
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32). Directed vectors with
// hand-computed expectations; the MUL scenarios are compiled when
// ALU_SEQ_MUL_EN is defined, otherwise op 12 is checked as illegal.
module tb_alu_seq;
    localparam int W = 32;

    logic       clk;
    logic       reset;
    logic [0:0] fsm_state;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Driver: present one request for a single edge, expected result queued.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_res);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        exp_q.push_back(exp_res);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Scoreboard: the cycle after issue must be a done carrying the queued result.
    task automatic check_done(input string tag);
        logic [W-1:0] exp_res;
        exp_res = exp_q.pop_front();
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n,
                               input logic v, input logic il);
        check({tag, "_zero"}, 64'(bus.zero), 64'(z));
        check({tag, "_neg"}, 64'(bus.negative), 64'(n));
        check({tag, "_ovf"}, 64'(bus.overflow), 64'(v));
        check({tag, "_illegal"}, 64'(bus.illegal), 64'(il));
    endtask

    int busy_cnt;
    int done_cnt;
    int done_cyc;
    logic [W-1:0] done_res;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 4'd0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_state", 64'(fsm_state), 64'd0);
        reset = 1'b0;

        issue(4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
        check_done("sum_ovf");
        check_flags("sum_ovf", 1'b0, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("hold_done", 64'(bus.done), 64'd0);
        check("hold_result", 64'(bus.result), 64'h8000_0000);

        // Back-to-back: SUB then SRA (only b[4:0] = 4 is used)
        issue(4'd2, 32'd5, 32'd5, 32'h0);
        check_done("sub_zero");
        check_flags("sub_zero", 1'b1, 1'b0, 1'b0, 1'b0);
        issue(4'd9, 32'h8000_0000, 32'h24, 32'hF800_0000);
        check_done("sra");
        check_flags("sra", 1'b0, 1'b1, 1'b0, 1'b0);

        issue(4'd10, 32'hFFFF_FFFF, 32'h1, 32'h1);
        check_done("slt");
        issue(4'd11, 32'hFFFF_FFFF, 32'h1, 32'h0);
        check_done("sltu");
        check("sltu_zero", 64'(bus.zero), 64'd1);

        issue(4'd1, 32'h1, 32'h21, 32'h2);
        check_done("shl");
        issue(4'd5, 32'h8000_0000, 32'h1F, 32'h1);
        check_done("shr");
        issue(4'd3, 32'hDEAD, 32'h1234_5678, 32'h1234_5678);
        check_done("load");
        issue(4'd4, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0);
        check_done("xor");
        issue(4'd6, 32'h0, 32'h5, 32'hFFFF_FFFF);
        check_done("not");
        issue(4'd7, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00);
        check_done("and");
        issue(4'd8, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
        check_done("or");
        issue(4'd2, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF);
        check_done("sub_ovf");
        check_flags("sub_ovf", 1'b0, 1'b0, 1'b1, 1'b0);
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
        check_done("sum_wrap");
        check_flags("sum_wrap", 1'b1, 1'b0, 1'b0, 1'b0);

        issue(4'd14, 32'h3, 32'h4, 32'h0);
        check_done("op14");
        check_flags("op14", 1'b1, 1'b0, 1'b0, 1'b1);
        issue(4'd0, 32'h1, 32'h1, 32'h2);
        check_done("after_ill");
        check("after_ill_illegal", 64'(bus.illegal), 64'd0);

`ifdef ALU_SEQ_MUL_EN
        // MUL: busy for 32 cycles, done at cycle 33, stray start ignored
        issue(4'd12, 32'hFFFF_FFFF, 32'h3, 32'hFFFF_FFFD);
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        done_res = '0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                done_res = bus.result;
            end
            if (cyc == 5) begin
                bus.start = 1'b1;
                bus.op    = 4'd0;
                bus.a     = 32'h1;
                bus.b     = 32'h1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        void'(exp_q.pop_front());
        check("mul_busy_cycles", 64'(busy_cnt), 64'd32);
        check("mul_done_cycle", 64'(done_cyc), 64'd33);
        check("mul_done_count", 64'(done_cnt), 64'd1);
        check("mul_result", 64'(done_res), 64'hFFFF_FFFD);

        // MUL aborted by reset at cycle 10
        issue(4'd12, 32'd7, 32'd9, 32'd63);
        void'(exp_q.pop_front());
        check("mul2_busy", 64'(bus.busy), 64'd1);
        repeat (9) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_result", 64'(bus.result), 64'd0);
        check("abort_done", 64'(bus.done), 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        issue(4'd0, 32'd2, 32'd3, 32'd5);
        check_done("post_abort_sum");
`else
        issue(4'd12, 32'd7, 32'd9, 32'h0);
        check_done("mul_off");
        check_flags("mul_off", 1'b1, 1'b0, 1'b0, 1'b1);
        check("mul_off_busy", 64'(bus.busy), 64'd0);
`endif

        // start and reset together: reset wins, start dropped
        issue(4'd0, 32'd1, 32'd1, 32'd2);
        check_done("pre_rst_sum");
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 4'd0;
        bus.a     = 32'd4;
        bus.b     = 32'd4;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check("rst_start_done", 64'(bus.done), 64'd0);
        check("rst_start_result", 64'(bus.result), 64'd0);
        @(posedge clk); #1;
        check("rst_start_late_done", 64'(bus.done), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
